// File: rtl/window_gen_pkg.sv
// Shared types and build-time defaults for the window_gen slice.
// Each macro may be overridden globally; otherwise it falls back to the value given here.
`ifndef NBIT
`define NBIT 8
`endif
`ifndef KERNEL_SIZE
`define KERNEL_SIZE 3
`endif
`ifndef IMG_WIDTH
`define IMG_WIDTH 640
`endif
`ifndef IMG_HEIGHT
`define IMG_HEIGHT 480
`endif

package window_gen_pkg;
  localparam int NBIT_DEF        = `NBIT;
  localparam int KERNEL_SIZE_DEF = `KERNEL_SIZE;
  localparam int IMG_WIDTH_DEF   = `IMG_WIDTH;
  localparam int IMG_HEIGHT_DEF  = `IMG_HEIGHT;

  typedef logic [NBIT_DEF-1:0] pixel_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_ACTIVE
  } state_t;
endpackage

// File: rtl/window_gen_line_buffer.sv
// Single-pointer circular line delay: o_data is the sample written DEPTH enables ago.
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr;

  // Read-before-write at the same slot yields the DEPTH-old sample.
  assign o_data = mem[ptr];

  always_ff @(posedge i_clk) begin
    if (i_en) mem[ptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr <= '0;
    end else if (i_en) begin
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
    end
  end
endmodule

// File: rtl/window_gen.sv
// Raster-scan sliding-window generator: K-1 line delays plus a KxK shift window,
// emitting one valid-mode window per accepted pixel with one-cycle latency.
module window_gen
  import window_gen_pkg::*;
#(
  parameter int NBIT        = NBIT_DEF,
  parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
  parameter int IMG_WIDTH   = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT  = IMG_HEIGHT_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NBIT-1:0] i_pixel,
  input  logic            i_pixel_valid,
  input  logic            i_sof,
  output logic [NBIT-1:0] o_window [KERNEL_SIZE][KERNEL_SIZE],
  output logic            o_window_valid,
  output logic            o_frame_done,
  output logic            o_busy
);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam logic [ROW_W-1:0] ROW_FULL = ROW_W'(KERNEL_SIZE - 1);
  localparam logic [COL_W-1:0] COL_FULL = COL_W'(KERNEL_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

  state_t           state;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;

  logic [NBIT-1:0] lb_in  [KERNEL_SIZE-1];
  logic [NBIT-1:0] lb_out [KERNEL_SIZE-1];

  assign lb_in[0] = i_pixel;

  for (genvar j = 0; j < KERNEL_SIZE - 1; j++) begin : g_lb
    if (j > 0) begin : g_chain
      assign lb_in[j] = lb_out[j-1];
    end
    line_buffer #(
      .DEPTH (IMG_WIDTH),
      .WIDTH (NBIT)
    ) u_line_buffer (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (i_pixel_valid),
      .i_data (lb_in[j]),
      .o_data (lb_out[j])
    );
  end

  // Coordinates of the pixel being accepted; i_sof (or an idle start) forces (0,0).
  logic [ROW_W-1:0] eff_row, next_row;
  logic [COL_W-1:0] eff_col, next_col;
  logic             in_window, last_pix;

  always_comb begin
    eff_row = row;
    eff_col = col;
    if (i_sof || state == S_IDLE) begin
      eff_row = '0;
      eff_col = '0;
    end
    in_window = (eff_row >= ROW_FULL) && (eff_col >= COL_FULL);
    last_pix  = (eff_row == ROW_LAST) && (eff_col == COL_LAST);
    next_col  = (eff_col == COL_LAST) ? '0 : eff_col + COL_W'(1);
    next_row  = (eff_col == COL_LAST) ? eff_row + ROW_W'(1) : eff_row;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= S_IDLE;
      row            <= '0;
      col            <= '0;
      o_window_valid <= 1'b0;
      o_frame_done   <= 1'b0;
      for (int unsigned r = 0; r < KERNEL_SIZE; r++)
        for (int unsigned c = 0; c < KERNEL_SIZE; c++)
          o_window[r][c] <= '0;
    end else begin
      o_window_valid <= 1'b0;
      o_frame_done   <= 1'b0;
      if (i_pixel_valid) begin
        for (int unsigned r = 0; r < KERNEL_SIZE; r++)
          for (int unsigned c = 0; c < KERNEL_SIZE - 1; c++)
            o_window[r][c] <= o_window[r][c+1];
        // Deepest line delay holds the oldest row, so it feeds row 0.
        for (int unsigned r = 0; r < KERNEL_SIZE - 1; r++)
          o_window[r][KERNEL_SIZE-1] <= lb_out[KERNEL_SIZE-2-r];
        o_window[KERNEL_SIZE-1][KERNEL_SIZE-1] <= i_pixel;

        o_window_valid <= in_window;
        o_frame_done   <= last_pix;
        if (last_pix) begin
          row   <= '0;
          col   <= '0;
          state <= S_IDLE;
        end else begin
          row   <= next_row;
          col   <= next_col;
          state <= (next_row >= ROW_FULL) ? S_ACTIVE : S_FILL;
        end
      end
    end
  end

  assign o_busy = (state != S_IDLE);
endmodule

// File: tb/tb_window_gen.sv
// Scoreboard bench for window_gen with K=3, W=5, H=4 and pixel = row*5+col.
module tb_window_gen;
  localparam int K = 3;
  localparam int W = 5;
  localparam int H = 4;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_pixel = '0;
  logic       i_pixel_valid = 1'b0;
  logic       i_sof = 1'b0;
  logic [7:0] o_window [K][K];
  logic       o_window_valid, o_frame_done, o_busy;

  window_gen #(
    .NBIT        (8),
    .KERNEL_SIZE (K),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_pixel        (i_pixel),
    .i_pixel_valid  (i_pixel_valid),
    .i_sof          (i_sof),
    .o_window       (o_window),
    .o_window_valid (o_window_valid),
    .o_frame_done   (o_frame_done),
    .o_busy         (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [71:0] win;
    logic        done;
  } exp_t;

  exp_t sb[$];
  int   strobe_idx[$];
  int   checks = 0;
  int   errors = 0;
  int   strobes = 0;
  int   dones = 0;

  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        w[(i*K+j)*8 +: 8] = 8'((r - K + 1 + i) * W + (c - K + 1 + j));
    return w;
  endfunction

  function automatic logic [71:0] pack_win();
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        w[(i*K+j)*8 +: 8] = o_window[i][j];
    return w;
  endfunction

  // Drives one cycle, then pops the scoreboard for any strobe that appears.
  task automatic drive(input logic [7:0] p, input logic sof, input logic vld);
    exp_t e;
    i_pixel = p;
    i_sof = sof;
    i_pixel_valid = vld;
    @(posedge i_clk);
    #1;
    if (o_window_valid === 1'b1) begin
      strobes++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got window %h, required no strobe", pack_win());
      end else begin
        e = sb.pop_front();
        if (pack_win() !== e.win || o_frame_done !== e.done) begin
          errors++;
          $display("FAIL window: got %h done=%b, required %h done=%b",
                   pack_win(), o_frame_done, e.win, e.done);
        end
      end
      if (o_frame_done === 1'b1) dones++;
    end else if (o_frame_done !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL done_without_valid: got done=%b, required 0", o_frame_done);
    end
  endtask

  task automatic send_frame(input bit gaps);
    int r, c;
    bit flag;
    logic [71:0] w;
    for (int idx = 0; idx < W*H; idx++) begin
      r = idx / W;
      c = idx % W;
      flag = (r >= K-1) && (c >= K-1);
      w = exp_win(r, c);
      if (flag) sb.push_back({w, idx == W*H-1});
      drive(8'(idx), idx == 0, 1'b1);
      checks++;
      if (o_window_valid !== flag) begin
        errors++;
        $display("FAIL strobe_timing: pixel %0d valid=%b, required %b", idx, o_window_valid, flag);
      end
      if (o_window_valid === 1'b1) strobe_idx.push_back(idx);
      if (idx == 0) begin
        checks++;
        if (o_busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_first: got %b, required 1", o_busy);
        end
      end
      if (gaps) begin
        drive(8'($urandom), 1'b0, 1'b0);
        if (flag) begin
          checks++;
          if (pack_win() !== w) begin
            errors++;
            $display("FAIL hold_gap: pixel %0d window %h, required %h", idx, pack_win(), w);
          end
        end
      end
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_end: got %b, required 0", o_busy);
    end
  endtask

  task automatic check_totals(input string name, input int exp_strobes, input int exp_dones);
    checks++;
    if (strobes != exp_strobes || dones != exp_dones || sb.size() != 0) begin
      errors++;
      $display("FAIL %s_totals: strobes=%0d dones=%0d left=%0d, required %0d %0d 0",
               name, strobes, dones, sb.size(), exp_strobes, exp_dones);
    end
    strobes = 0;
    dones = 0;
    sb.delete();
    strobe_idx.delete();
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    drive(8'h00, 1'b0, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    checks++;
    if (o_window_valid !== 1'b0 || o_frame_done !== 1'b0 || o_busy !== 1'b0 || pack_win() !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b done=%b busy=%b win=%h, required 0 0 0 0",
               o_window_valid, o_frame_done, o_busy, pack_win());
    end
    i_rst = 1'b0;
    drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_full_frame();
    send_frame(1'b0);
    drive(8'h00, 1'b0, 1'b0);
    check_totals("full_frame", 6, 1);
  endtask

  task automatic test_gaps();
    send_frame(1'b1);
    drive(8'h00, 1'b0, 1'b0);
    check_totals("gaps", 6, 1);
  endtask

  task automatic test_row_wrap();
    int expected_idx[6] = '{12, 13, 14, 17, 18, 19};
    send_frame(1'b0);
    checks++;
    if (strobe_idx.size() != 6) begin
      errors++;
      $display("FAIL row_wrap_count: got %0d strobes, required 6", strobe_idx.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (strobe_idx[i] != expected_idx[i]) begin
          errors++;
          $display("FAIL row_wrap: strobe %0d after pixel %0d, required %0d",
                   i, strobe_idx[i], expected_idx[i]);
        end
      end
    end
    drive(8'h00, 1'b0, 1'b0);
    check_totals("row_wrap", 6, 1);
  endtask

  task automatic test_back_to_back();
    send_frame(1'b0);
    send_frame(1'b0);
    drive(8'h00, 1'b0, 1'b0);
    check_totals("back_to_back", 12, 2);
  endtask

  task automatic test_early_restart();
    for (int idx = 0; idx < 8; idx++) drive(8'(idx), idx == 0, 1'b1);
    send_frame(1'b0);
    drive(8'h00, 1'b0, 1'b0);
    check_totals("early_restart", 6, 1);
  endtask

  task automatic test_mid_reset();
    int r, c;
    for (int idx = 0; idx < 14; idx++) begin
      r = idx / W;
      c = idx % W;
      if (r >= K-1 && c >= K-1) sb.push_back({exp_win(r, c), 1'b0});
      drive(8'(idx), idx == 0, 1'b1);
    end
    i_rst = 1'b1;
    drive(8'd14, 1'b0, 1'b1);
    i_rst = 1'b0;
    drive(8'h00, 1'b0, 1'b0);
    checks++;
    if (o_window_valid !== 1'b0 || o_busy !== 1'b0 || pack_win() !== '0) begin
      errors++;
      $display("FAIL mid_reset_state: valid=%b busy=%b win=%h, required 0 0 0",
               o_window_valid, o_busy, pack_win());
    end
    check_totals("mid_reset_partial", 2, 0);
    send_frame(1'b0);
    drive(8'h00, 1'b0, 1'b0);
    check_totals("mid_reset", 6, 1);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_gaps();
    test_row_wrap();
    test_back_to_back();
    test_early_restart();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/window_gen.md
Name: window_gen

Overview:
- Streaming sliding-window generator feeding conv_block; the producer side of conv_block's window/valid interface.
- Accepts a raster-scan pixel stream, one pixel per valid cycle, row-major.
- Buffers K-1 image lines and emits a KERNEL_SIZE x KERNEL_SIZE window with a one-cycle valid strobe that drives conv_block i_data / i_data_valid directly.
- Valid-mode only (no border padding); one window per accepted pixel once the window is fully inside the frame.

Parameters:
- NBIT, 8, pixel width in bits (`NBIT from params.sv).
- KERNEL_SIZE, 3, window side length K, K>=2 (`KERNEL_SIZE).
- IMG_WIDTH, 640, pixels per line W, W>=K.
- IMG_HEIGHT, 480, lines per frame H, H>=K.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_pixel  in  NBIT  input pixel.
- i_pixel_valid  in  1  i_pixel is accepted this cycle.
- i_sof  in  1  start of frame; qualified by i_pixel_valid; marks this pixel as (0,0).
- o_window  out  NBIT x [K][K] unpacked  window; [r][c], r=0 is the oldest row, c=0 the leftmost column.
- o_window_valid  out  1  single-cycle strobe; o_window is valid.
- o_frame_done  out  1  single-cycle pulse on the last window of the frame.
- o_busy  out  1  high while state != S_IDLE.

Behaviour:
- Reset: o_window_valid=0, o_frame_done=0, o_busy=0, o_window all zero, row/col counters=0, state=S_IDLE.
- Line-buffer RAM contents are not cleared; they are don't-care because valid is gated.
- No backpressure; the downstream block must accept every strobe.
- Accepted pixel at (row,col):
  - shift window regs left by one column;
  - new right column c=K-1 = {line_buf[K-2] out, ..., line_buf[0] out, i_pixel}, top to bottom;
  - push i_pixel into line_buf[0] and line_buf[j] out into line_buf[j+1].
- Latency: 1 cycle. o_window_valid asserts the cycle after accepting pixel (row,col) iff row>=K-1 and col>=K-1.
  - Window then covers rows row-K+1..row and cols col-K+1..col.
  - o_window[K-1][K-1] = that pixel.
- Windows per frame: (H-K+1)*(W-K+1).
- Cycles with i_pixel_valid=0: no shift, no line-buffer push, counters hold, o_window holds, o_window_valid=0.
- Counters:
  - col wraps W-1 -> 0 and row increments.
  - At (H-1,W-1): o_frame_done pulses with the final o_window_valid, counters return to 0, state -> S_IDLE.
- FSM:
  - S_IDLE -> S_FILL on any accepted pixel; i_sof is optional here and that pixel is (0,0).
  - S_FILL (row<K-1) -> S_ACTIVE when row reaches K-1.
  - S_ACTIVE -> S_IDLE after the last frame pixel.
- i_sof with valid in S_FILL/S_ACTIVE (early restart):
  - counters forced so this pixel is (0,0), state -> S_FILL;
  - no o_frame_done for the aborted frame; no window emitted from this pixel.
- i_sof without i_pixel_valid: ignored.
- Reset mid-frame: counters cleared, state -> S_IDLE, any pending valid suppressed on the next cycle.
- Width rule: row counter is $clog2(IMG_HEIGHT) bits, col counter is $clog2(IMG_WIDTH) bits; no arithmetic on pixel data.

Decomposition:
- params.sv supplies NBIT, KERNEL_SIZE, IMG_WIDTH, IMG_HEIGHT defaults.
- Shared package holds the state enum (S_IDLE, S_FILL, S_ACTIVE) and a pixel typedef logic [NBIT-1:0].
- One sub-module: line_buffer (depth IMG_WIDTH, width NBIT, shift-on-enable, circular RAM with a single pointer, output = value written W enables earlier).
- window_gen instantiates K-1 line_buffer instances.

Test Plan (K=3, W=5, H=4, pixel = row*5+col, continuous valid, i_sof on first pixel):
- Full frame: first o_window_valid one cycle after pixel 12 with window [[0,1,2],[5,6,7],[10,11,12]]; exactly 6 strobes total; last window [[7,8,9],[12,13,14],[17,18,19]] with o_frame_done=1 that cycle.
- Same frame with i_pixel_valid low on every other cycle: the same 6 windows in the same order; o_window holds during gaps; never two consecutive strobes.
- Row wrap: after pixel 14 the next strobe is after pixel 17, never after 15 or 16.
- Back-to-back frames with no idle cycle: second frame windows identical to the first; two o_frame_done pulses.
- i_sof reasserted on pixel 8 of frame 1, then a full frame: no o_frame_done for the aborted frame; then 6 correct windows and one o_frame_done.
- i_rst held one cycle after pixel 13, then a full frame: no strobe in the cycle after reset; o_busy=0; the following full frame produces the 6 correct windows.
